spk_memory_writer: RTL and testbench

SPK_MEMORY_WRITER -- requirements
Module: spk_memory_writer

---
 rtl/spk_memory_writer_pkg.sv | 8 +
 rtl/spk_memory_writer_if.sv | 25 ++
 rtl/spk_memory_writer_packer.sv | 31 +++
 rtl/spk_memory_writer.sv | 82 ++++++++
 tb/tb_spk_memory_writer.sv | 174 +++++++++++++++++
 5 files changed

// File: rtl/spk_memory_writer_pkg.sv
// spk_memory_writer_pkg: shared widths and FSM state encoding for the spike memory writer.
package spk_memory_writer_pkg;
    localparam int SPK_WORD_W   = 16;
    localparam int SPK_ADDR_W   = 9;
    localparam int SPK_BANK_BIT = 8;
    localparam int SPK_CNT_W    = 4;
    typedef enum logic [1:0] {ST_IDLE, ST_PACK, ST_DONE} spk_state_e;
endpackage

// File: rtl/spk_memory_writer_if.sv
// spk_memory_writer_if: spike input stream and SRAM write port of the spike memory writer.
interface spk_memory_writer_if;
    import spk_memory_writer_pkg::*;
    logic                  step_start;
    logic                  spk_valid;
    logic                  spk_in;
    logic                  spk_last;
    logic                  spk_ready;
    logic [SPK_WORD_W-1:0] spk_write_sram;
    logic [SPK_ADDR_W-1:0] spk_write_sram_addr;
    logic                  spk_write_sram_we;
    logic                  read_bank;
    logic                  step_done;
    logic                  overflow;
    modport master (
        output step_start, spk_valid, spk_in, spk_last,
        input  spk_ready, spk_write_sram, spk_write_sram_addr, spk_write_sram_we,
        input  read_bank, step_done, overflow
    );
    modport slave (
        input  step_start, spk_valid, spk_in, spk_last,
        output spk_ready, spk_write_sram, spk_write_sram_addr, spk_write_sram_we,
        output read_bank, step_done, overflow
    );
endinterface

// File: rtl/spk_memory_writer_packer.sv
// spk_word_packer: serial-to-16-bit LSB-first packer with bit counter and word-complete flag.
module spk_word_packer
    import spk_memory_writer_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clr_i,
    input  logic                  en_i,
    input  logic                  bit_i,
    input  logic                  last_i,
    output logic [SPK_WORD_W-1:0] word_o,
    output logic                  done_o
);
    logic [SPK_WORD_W-1:0] pack_q, pack_d;
    logic [SPK_CNT_W-1:0]  cnt_q, cnt_d;
    always_comb begin
        word_o = pack_q | (SPK_WORD_W'(bit_i) << cnt_q);
        done_o = en_i & ((cnt_q == SPK_CNT_W'(SPK_WORD_W - 1)) | last_i);
        pack_d = (clr_i | done_o) ? '0 : en_i ? word_o : pack_q;
        cnt_d  = (clr_i | done_o) ? '0 : en_i ? cnt_q + SPK_CNT_W'(1) : cnt_q;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            pack_q <= '0;
            cnt_q  <= '0;
        end else begin
            pack_q <= pack_d;
            cnt_q  <= cnt_d;
        end
    end
endmodule

// File: rtl/spk_memory_writer.sv
// spk_memory_writer: packs a per-timestep spike stream into 16-bit words written to a
// double-banked SRAM; the bank toggles after each completed timestep.
module spk_memory_writer
    import spk_memory_writer_pkg::*;
#(
    parameter int MAX_WORDS = 256
) (
    input  logic                 clk,
    input  logic                 reset,
    spk_memory_writer_if.slave   bus
);
    spk_state_e            state_q;
    logic [SPK_ADDR_W-1:0] word_idx_q;
    logic                  write_bank_q, read_bank_q;
    logic [SPK_WORD_W-1:0] data_q;
    logic [SPK_ADDR_W-1:0] addr_q;
    logic                  we_q, step_done_q, overflow_q;
    logic                  accept, take_last, clr, en, word_done;
    logic [SPK_WORD_W-1:0] word;
    always_comb begin
        accept    = bus.spk_valid & (state_q == ST_PACK);
        take_last = accept & bus.spk_last;
        // a start pulse restarts the timestep except in DONE or when it collides with the last bit
        clr       = bus.step_start & (state_q != ST_DONE) & ~take_last;
        en        = accept & ~clr;
    end
    spk_word_packer u_packer (
        .clk    (clk),
        .reset  (reset),
        .clr_i  (clr),
        .en_i   (en),
        .bit_i  (bus.spk_in),
        .last_i (bus.spk_last),
        .word_o (word),
        .done_o (word_done)
    );
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            word_idx_q   <= '0;
            write_bank_q <= 1'b0;
            read_bank_q  <= 1'b1;
            data_q       <= '0;
            addr_q       <= '0;
            we_q         <= 1'b0;
            step_done_q  <= 1'b0;
            overflow_q   <= 1'b0;
        end else begin
            we_q        <= 1'b0;
            step_done_q <= 1'b0;
            if (clr)
                word_idx_q <= '0;
            if (word_done) begin
                if (word_idx_q == SPK_ADDR_W'(MAX_WORDS))
                    overflow_q <= 1'b1;
                else begin
                    we_q       <= 1'b1;
                    data_q     <= word;
                    addr_q     <= {write_bank_q, word_idx_q[SPK_BANK_BIT-1:0]};
                    word_idx_q <= word_idx_q + SPK_ADDR_W'(1);
                end
            end
            case (state_q)
                ST_IDLE: if (bus.step_start) state_q <= ST_PACK;
                ST_PACK: if (take_last) begin
                    state_q      <= ST_DONE;
                    step_done_q  <= 1'b1;
                    read_bank_q  <= write_bank_q;
                    write_bank_q <= ~write_bank_q;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end
    assign bus.spk_ready           = state_q == ST_PACK;
    assign bus.spk_write_sram      = data_q;
    assign bus.spk_write_sram_addr = addr_q;
    assign bus.spk_write_sram_we   = we_q;
    assign bus.read_bank           = read_bank_q;
    assign bus.step_done           = step_done_q;
    assign bus.overflow            = overflow_q;
endmodule

// File: tb/tb_spk_memory_writer.sv
// tb_spk_memory_writer: drives identical spike streams into a full-size writer and a
// MAX_WORDS=2 writer, checking each against words computed from the bit array.
module tb_spk_memory_writer;
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    spk_memory_writer_if ia();
    spk_memory_writer_if ib();
    spk_memory_writer #(.MAX_WORDS(256)) u_a (.clk(clk), .reset(reset), .bus(ia));
    spk_memory_writer #(.MAX_WORDS(2))   u_b (.clk(clk), .reset(reset), .bus(ib));

    int total = 0;
    int bad = 0;
    bit sb [0:255];
    logic bank = 1'b0;
    logic ovf_b = 1'b0;
    logic [15:0] last_a = '0, last_b = '0;
    logic [8:0] lad_a = '0, lad_b = '0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic s, input logic v, input logic b, input logic l);
        ia.step_start = s; ia.spk_valid = v; ia.spk_in = b; ia.spk_last = l;
        ib.step_start = s; ib.spk_valid = v; ib.spk_in = b; ib.spk_last = l;
        @(negedge clk);
    endtask

    task automatic chk_nowrite(input string tag);
        chk({tag, "_we_a"}, ia.spk_write_sram_we, 0);
        chk({tag, "_we_b"}, ib.spk_write_sram_we, 0);
        chk({tag, "_hold_a"}, {ia.spk_write_sram_addr, ia.spk_write_sram}, {lad_a, last_a});
        chk({tag, "_hold_b"}, {ib.spk_write_sram_addr, ib.spk_write_sram}, {lad_b, last_b});
    endtask

    function automatic logic [15:0] exp_word(input int k, input int n);
        logic [15:0] w = '0;
        for (int j = 0; j < 16; j++)
            if (16 * k + j < n) w[j] = sb[16 * k + j];
        return w;
    endfunction

    task automatic do_step(input int n, input bit gaps, input int abort_at, input bit noise);
        int k;
        if (noise)
            repeat (3) begin
                chk("idle_rdy", ia.spk_ready, 0);
                drive(0, 1, 1'($urandom), 1'($urandom));
                chk_nowrite("idle");
            end
        chk("start_rdy", ia.spk_ready, 0);
        drive(1, noise, 1, 0);
        chk_nowrite("start");
        if (abort_at > 0) begin
            for (int i = 0; i < abort_at; i++) begin
                drive(0, 1, 1'($urandom), 0);
                chk_nowrite("pre_abort");
            end
            drive(1, 0, 0, 0);
            chk_nowrite("abort");
            chk("abort_sd", ia.step_done, 0);
        end
        for (int i = 0; i < n; i++) begin
            if (gaps)
                repeat ($urandom_range(0, 2)) begin
                    drive(0, 0, 1'($urandom), 1'($urandom));
                    chk_nowrite("gap");
                end
            chk("pack_rdy_a", ia.spk_ready, 1);
            chk("pack_rdy_b", ib.spk_ready, 1);
            drive((i == n - 1) ? 1'($urandom) : 1'b0, 1, sb[i], i == n - 1);
            k = i / 16;
            if (i % 16 == 15 || i == n - 1) begin
                last_a = exp_word(k, n);
                lad_a = {bank, 8'(k)};
                chk("wr_we_a", ia.spk_write_sram_we, 1);
                chk("wr_data_a", ia.spk_write_sram, last_a);
                chk("wr_addr_a", ia.spk_write_sram_addr, lad_a);
                if (k < 2) begin
                    last_b = last_a;
                    lad_b = lad_a;
                    chk("wr_we_b", ib.spk_write_sram_we, 1);
                    chk("wr_b", {ib.spk_write_sram_addr, ib.spk_write_sram}, {lad_b, last_b});
                end else begin
                    chk("ovf_we_b", ib.spk_write_sram_we, 0);
                    chk("ovf_hold_b", {ib.spk_write_sram_addr, ib.spk_write_sram}, {lad_b, last_b});
                end
            end else
                chk_nowrite("bit");
            chk("sd_a", ia.step_done, i == n - 1);
            chk("sd_b", ib.step_done, i == n - 1);
        end
        ovf_b = ovf_b | ((n + 15) / 16 > 2);
        chk("rb_a", ia.read_bank, bank);
        chk("rb_b", ib.read_bank, bank);
        chk("ovf_a", ia.overflow, 0);
        chk("ovf_b", ib.overflow, ovf_b);
        bank = ~bank;
        chk("done_rdy", ia.spk_ready, 0);
        drive(1, 1, 1, 1);
        chk_nowrite("done");
        chk("done_sd_clr", ia.step_done, 0);
        chk("done_ss_ign", ia.spk_ready, 0);
        drive(0, 0, 0, 0);
    endtask

    initial begin
        logic [15:0] pat;
        drive(0, 0, 0, 0);
        repeat (2) drive(0, 1, 1, 1);
        chk("rst_we", ia.spk_write_sram_we, 0);
        chk("rst_data", ia.spk_write_sram, 0);
        chk("rst_addr", ia.spk_write_sram_addr, 0);
        chk("rst_sd", ia.step_done, 0);
        chk("rst_ovf", ia.overflow, 0);
        chk("rst_rb", ia.read_bank, 1);
        chk("rst_rdy", ia.spk_ready, 0);
        reset = 1'b0;
        drive(0, 0, 0, 0);

        pat = 16'hA5C3;
        for (int i = 0; i < 16; i++) sb[i] = pat[i];
        do_step(16, 0, 0, 0);
        chk("a5c3_rb", ia.read_bank, 0);

        for (int i = 0; i < 20; i++) sb[i] = 1'b1;
        do_step(20, 0, 0, 0);
        chk("ones_rb", ia.read_bank, 1);

        for (int i = 0; i < 37; i++) sb[i] = 1'($urandom);
        do_step(37, 1, 0, 1);

        pat = 16'h1234;
        for (int i = 0; i < 16; i++) sb[i] = pat[i];
        do_step(16, 0, 10, 0);

        for (int i = 0; i < 48; i++) sb[i] = 1'($urandom);
        do_step(48, 0, 0, 0);

        repeat (6) begin
            int n = $urandom_range(1, 70);
            for (int i = 0; i < n; i++) sb[i] = 1'($urandom);
            do_step(n, 1'($urandom), 0, 1'($urandom));
        end

        drive(1, 0, 0, 0);
        for (int i = 0; i < 15; i++) drive(0, 1, 1'($urandom), 0);
        reset = 1'b1;
        drive(0, 1, 1, 0);
        chk("mid_rst_we", ia.spk_write_sram_we, 0);
        chk("mid_rst_data", ia.spk_write_sram, 0);
        chk("mid_rst_addr", ia.spk_write_sram_addr, 0);
        chk("mid_rst_rb", ia.read_bank, 1);
        chk("mid_rst_rdy", ia.spk_ready, 0);
        chk("mid_rst_ovf_b", ib.overflow, 0);
        chk("mid_rst_sd", ia.step_done, 0);
        reset = 1'b0;
        bank = 1'b0;
        ovf_b = 1'b0;
        last_a = '0; last_b = '0; lad_a = '0; lad_b = '0;
        drive(0, 0, 0, 0);
        for (int i = 0; i < 33; i++) sb[i] = 1'($urandom);
        do_step(33, 1, 0, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
